// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration request handler.
package cfg_pkg;

  // Handler FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    CPL     = 2'd3
  } cfg_state_e;

  // Completion status encodings.
  localparam logic [2:0] CPL_SC = 3'b000;  // successful completion
  localparam logic [2:0] CPL_UR = 3'b001;  // unsupported request

endpackage

// File: rtl/cfg_be_merge.sv
// Byte-enable merge: each enabled byte is taken from new_data, the rest from old_data.
module cfg_be_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  // Select each byte lane independently; bit i of be controls byte i.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    merged = old_data;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/cfg_req_handler.sv
// Type 0 configuration request handler: accepts one CfgRd0/CfgWr0 at a time,
// performs a read (and read-modify-write for writes) on the config space and
// returns a single completion.
module cfg_req_handler
  import cfg_pkg::*;
#(
  parameter int          DW_COUNT     = 32,
  parameter logic [15:0] COMPLETER_ID = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst,
  // Request side
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_is_write,
  input  logic [9:0]                  req_reg_num,
  input  logic [3:0]                  req_first_be,
  input  logic [31:0]                 req_data,
  input  logic [15:0]                 req_requester_id,
  input  logic [7:0]                  req_tag,
  // Config-space side
  output logic                        cfg_wr_en,
  output logic [$clog2(DW_COUNT)-1:0] cfg_addr,
  output logic [31:0]                 cfg_data_in,
  input  logic [31:0]                 cfg_data_out,
  // Completion side
  output logic                        cpl_valid,
  input  logic                        cpl_ready,
  output logic [2:0]                  cpl_status,
  output logic                        cpl_has_data,
  output logic [31:0]                 cpl_data,
  output logic [15:0]                 cpl_requester_id,
  output logic [7:0]                  cpl_tag,
  output logic [15:0]                 cpl_completer_id
);

  localparam int AW = $clog2(DW_COUNT);

  cfg_state_e  state_q;
  logic [AW-1:0] addr_q;
  logic        is_write_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic        wr_en_q;
  logic [31:0] data_in_q;
  logic        cpl_valid_q;
  logic [2:0]  cpl_status_q;
  logic        cpl_has_data_q;
  logic [31:0] cpl_data_q;

  logic        in_range;
  logic [31:0] merged_d;

  assign in_range = ({22'd0, req_reg_num} < 32'(DW_COUNT));

  // Write data is the captured register value with the request bytes merged in.
  cfg_be_merge u_be_merge (
    .old_data (cfg_data_out),
    .new_data (wdata_q),
    .be       (be_q),
    .merged   (merged_d)
  );

  // Request handling FSM with registered config-space and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
      state_q        <= IDLE;
      addr_q         <= '0;
      is_write_q     <= 1'b0;
      be_q           <= '0;
      wdata_q        <= '0;
      rid_q          <= '0;
      tag_q          <= '0;
      wr_en_q        <= 1'b0;
      data_in_q      <= '0;
      cpl_valid_q    <= 1'b0;
      cpl_status_q   <= CPL_SC;
      cpl_has_data_q <= 1'b0;
      cpl_data_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            is_write_q <= req_is_write;
            be_q       <= req_first_be;
            wdata_q    <= req_data;
            rid_q      <= req_requester_id;
            tag_q      <= req_tag;
            if (in_range) begin
              addr_q  <= req_reg_num[AW-1:0];
              state_q <= RD_WAIT;
            end else begin
              // Out-of-range register: complete immediately as UR, no access.
              cpl_status_q   <= CPL_UR;
              cpl_has_data_q <= 1'b0;
              cpl_data_q     <= '0;
              cpl_valid_q    <= 1'b1;
              state_q        <= CPL;
            end
          end
        end
        RD_WAIT: begin
          if (is_write_q) begin
            data_in_q <= merged_d;
            wr_en_q   <= 1'b1;
            state_q   <= WRITE;
          end else begin
            cpl_data_q     <= cfg_data_out;
            cpl_status_q   <= CPL_SC;
            cpl_has_data_q <= 1'b1;
            cpl_valid_q    <= 1'b1;
            state_q        <= CPL;
          end
        end
        WRITE: begin
          wr_en_q        <= 1'b0;
          cpl_status_q   <= CPL_SC;
          cpl_has_data_q <= 1'b0;
          cpl_data_q     <= '0;
          cpl_valid_q    <= 1'b1;
          state_q        <= CPL;
        end
        CPL: begin
          if (cpl_ready) begin
            cpl_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready        = (state_q == IDLE) && !rst;
  assign cfg_wr_en        = wr_en_q;
  assign cfg_addr         = addr_q;
  assign cfg_data_in      = data_in_q;
  assign cpl_valid        = cpl_valid_q;
  assign cpl_status       = cpl_status_q;
  assign cpl_has_data     = cpl_has_data_q;
  assign cpl_data         = cpl_data_q;
  assign cpl_requester_id = rid_q;
  assign cpl_tag          = tag_q;
  assign cpl_completer_id = COMPLETER_ID;

endmodule
